// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

    // Register specifier, same shape as cpu_types_pkg::regbits_t.
    typedef logic [4:0] regbits_t;

    // Register 0 is hardwired to zero and never creates a dependency.
    localparam regbits_t REG_ZERO = '0;

    // Controller FSM.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } hzd_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat.sv
// Saturating up-counter. A clear restarts the count, and an inc in the same
// cycle counts as the first event of the new run.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count up and hold at all-ones.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            cnt <= '0;
        else if (clear)
            cnt <= W'(inc);
        else if (inc && (cnt != '1))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the five-stage pipeline.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int DWAIT_MAX = 1024
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  regbits_t         ifid_rs,
    input  regbits_t         ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             idex_dREN,
    input  regbits_t         idex_rt,
    input  logic             exmem_dREN,
    input  logic             exmem_dWEN,
    input  logic             ex_redirect,
    input  logic             halt_wb,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             memwb_flush,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
);

    localparam int WD_W = $clog2(DWAIT_MAX + 1);

    hzd_state_t      state, state_nxt;
    logic            mem_req;
    logic            wait_now;
    logic            load_use;
    logic            stall_inc;
    logic            flush_inc;
    logic            wd_clear;
    logic            wd_hit;
    logic [WD_W-1:0] wd_cnt;

    assign mem_req = exmem_dREN | exmem_dWEN;

    // A data access is outstanding: either a new unserved request in RUN, or
    // an earlier one still waiting in DWAIT.
    assign wait_now = ((state == RUN) && mem_req && !dhit) ||
                      ((state == DWAIT) && !dhit);

    assign load_use = idex_dREN && (idex_rt != REG_ZERO) &&
                      ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

    // Latch controls, highest-priority hazard first.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        exmem_flush = 1'b0;
        memwb_en    = 1'b1;
        memwb_flush = 1'b0;
        if (!nRST) begin
            // Hold everything and keep bubbles at every latch input.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (state == HALT) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (wait_now) begin
            // Freeze the front of the pipe; WB sees bubbles until memory answers.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (ex_redirect) begin
            // Wrong-path IF/ID and ID/EX are dropped; a missed fetch is moot.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    // Next-state logic; halt overrides everything and only reset leaves HALT.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (wait_now) state_nxt = DWAIT;
            DWAIT:   if (dhit)     state_nxt = RUN;
            HALT:    state_nxt = HALT;
            default: state_nxt = RUN;
        endcase
        if (halt_wb)
            state_nxt = HALT;
    end

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state <= RUN;
        else
            state <= state_nxt;
    end

    assign halted = (state == HALT);

    assign stall_inc = !pc_en && (state != HALT);
    assign flush_inc = ex_redirect && (state != HALT) && !wait_now;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .clear (1'b0),
        .inc   (stall_inc),
        .cnt   (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .clear (1'b0),
        .inc   (flush_inc),
        .cnt   (flush_cycles)
    );

    // Watchdog counts every waiting cycle; it restarts on each new wait since
    // it is held clear whenever we are not already in DWAIT.
    assign wd_clear = (state != DWAIT);

    sat_counter #(.W(WD_W)) u_wd_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .clear (wd_clear),
        .inc   (wait_now),
        .cnt   (wd_cnt)
    );

    // True in the wait cycle that brings the count up to DWAIT_MAX.
    assign wd_hit = wait_now &&
                    (wd_clear ? (DWAIT_MAX <= 1) : (wd_cnt >= WD_W'(DWAIT_MAX - 1)));

    // Sticky timeout flag; informational only.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            mem_timeout <= 1'b0;
        else if (wd_hit)
            mem_timeout <= 1'b1;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage pipeline. It reads hazard-relevant fields leaving the IF/ID, ID/EX and EX/MEM latches and drives the `en`/`flush` inputs of every pipeline latch and the PC enable. It resolves four hazard classes:
- load-use
- taken branch/jump
- instruction-memory wait
- data-memory wait

A small FSM tracks data-memory waits and halt, and saturating performance counters record stall and flush cycles.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters
- DWAIT_MAX, 1024, data-wait cycles before `mem_timeout` sets

Ports (reset is asynchronous and active-low; one clock):
- CLK  in  1  pipeline clock
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction fetch completed this cycle
- dhit  in  1  data access completed this cycle
- ifid_rs, ifid_rt  in  5 each  source registers of the instruction in ID
- ifid_uses_rt  in  1  ID instruction reads rt as a source
- idex_dREN  in  1  instruction in EX is a load
- idex_rt  in  5  destination of the load in EX
- exmem_dREN, exmem_dWEN  in  1 each  memory request in MEM
- ex_redirect  in  1  EX resolved a taken branch, jr or jump
- halt_wb  in  1  halt instruction has reached MEM/WB output
- pc_en  out  1  PC register update
- ifid_en, ifid_flush  out  1 each  IF/ID latch controls
- idex_en, idex_flush  out  1 each  ID/EX latch controls
- exmem_en, exmem_flush  out  1 each  EX/MEM latch controls
- memwb_en, memwb_flush  out  1 each  MEM/WB latch controls
- halted  out  1  sticky halt indication
- mem_timeout  out  1  sticky data-wait watchdog flag
- stall_cycles  out  CNT_W  cycles in which pc_en=0 while not halted
- flush_cycles  out  CNT_W  cycles in which ex_redirect caused a flush

## Operation
- FSM states are RUN, DWAIT and HALT. Reset enters RUN.
- **RUN → HALT:** when halt_wb=1. This has the highest priority from any state.
- **RUN → DWAIT:** when (exmem_dREN|exmem_dWEN)=1 and dhit=0.
- **DWAIT → RUN:** on the cycle dhit=1.
- Per-cycle control in RUN, highest priority first:
  1. **Data memory pending** ((exmem_dREN|exmem_dWEN) and !dhit): freeze the PC and the IF/ID, ID/EX and EX/MEM latches; memwb_flush=1.
  2. **ex_redirect:** pc_en=1, ifid_flush=1, idex_flush=1, all enables=1. An ihit=0 fetch in the same cycle is discarded, because IF/ID is flushed.
  3. **Load-use** (idex_dREN and idex_rt≠0 and (idex_rt==ifid_rs or (ifid_uses_rt and idex_rt==ifid_rt))): pc_en=0, ifid_en=0, idex_flush=1, downstream enables=1.
  4. **ihit=0:** pc_en=0, ifid_flush=1, downstream enables=1.
  5. **Otherwise:** all enables=1, all flushes=0.
- In DWAIT, outputs are the same as rule 1 until dhit. In the dhit cycle, rules 2–5 are evaluated normally.
- In HALT: all enables=0, all flushes=0, halted=1. Counters freeze. Only nRST leaves HALT.
- **Watchdog:** a DWAIT cycle counter clears on entry to DWAIT. When it reaches DWAIT_MAX, mem_timeout sets. mem_timeout is sticky until reset and does not alter control.
- **Counters:** unsigned and saturating at all-ones; they never wrap.

## Timing
- All latch controls are combinational from current inputs and state; there is zero-cycle latency from hazard to control.
- The FSM, counters, halted and mem_timeout are registered on the CLK rising edge.
- **Reset values:**
  - state=RUN; halted=0, mem_timeout=0, counters=0.
  - Combinational outputs while nRST=0: pc_en=0, all enables=0, all flushes=1.
- The load-use bubble lasts exactly 1 cycle when ihit=1 and dhit does not intervene.
- A redirect costs 2 bubbles, corresponding to the flushed IF/ID and ID/EX contents.
- A flush and an enable both asserted on one latch means the latch loads a bubble; the latch handles this, and the controller may assert both.
- halt_wb and ex_redirect in the same cycle: HALT wins from the next edge. The current cycle still applies the redirect.
- Asserting nRST mid-DWAIT returns to RUN immediately and clears the watchdog.

## Structure
- A shared package provides the FSM enum (`hzd_state_t`: RUN, DWAIT, HALT) and `regbits_t` from `cpu_types_pkg`.
- Register 0 is represented by a named constant, not a literal.
- One sub-module, `sat_counter` (parameterised width, inc, clear), is instantiated for stall_cycles, flush_cycles and the watchdog.

## Test plan
- **Reset:** nRST=0 with random inputs → pc_en=0, all *_flush=1, counters=0. Release with ihit=1 → all enables=1 and all flushes=0 on the next cycle.
- **Load-use:** idex_dREN=1, idex_rt=5, ifid_rs=5, ihit=1 → one cycle of pc_en=0, ifid_en=0, idex_flush=1, then normal operation; stall_cycles=1.
- **Load-use on register 0:** same stimulus with idex_rt=0 → no stall.
- **Data wait:** exmem_dREN=1, dhit=0 for 3 cycles, then dhit=1 → state is DWAIT for 3 cycles, memwb_flush=1 and the other enables=0 throughout; stall_cycles=3.
- **Redirect collision:** ex_redirect=1 with ihit=0 → ifid_flush=1, idex_flush=1, pc_en=1; flush_cycles increments by 1.
- **Halt:** halt_wb=1 during ex_redirect → next cycle halted=1 and all controls 0. A DWAIT_MAX=4 stall of 5 cycles in a separate run sets mem_timeout at cycle 4, and it stays set.
